// File: rtl/mem_pkg.sv
// Shared types and helpers for the main-memory responder: FSM state encoding,
// default geometry, and byte-address to word-index conversion.
package mem_pkg;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_DEPTH_LOG2 = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Drops the byte offset and keeps the low depth_log2 bits of the word address.
  function automatic logic [31:0] word_idx(input logic [63:0] byte_addr,
                                           input int unsigned depth_log2);
    return 32'((byte_addr >> 2) & ((64'd1 << depth_log2) - 64'd1));
  endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Down-counter used to model main-memory access latency: load, decrement, zero flag.
module mem_latency_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/main_mem_responder.sv
// Word-addressed main-memory responder with fixed access latency and req/ready/valid handshake.
// Optional MEM_ERR_EN adds an err output flagging out-of-range addresses.
module main_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int unsigned LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              valid,
`ifdef MEM_ERR_EN
  output logic              err,
`endif
  output logic [DATA_W-1:0] q
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              valid_q, valid_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              mem_we;
  logic              oor;
  logic [DEPTH_LOG2-1:0] idx;

  logic [DATA_W-1:0] mem [DEPTH];

  assign idx = DEPTH_LOG2'(word_idx(64'(addr_q), DEPTH_LOG2));

`ifdef MEM_ERR_EN
  logic err_q, err_d;
  assign oor = (addr_q[ADDR_W-1:DEPTH_LOG2+2] != '0);
  assign err = err_q;
`else
  assign oor = 1'b0;
`endif

  mem_latency_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(LATENCY - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    data_d   = data_q;
    q_d      = q_q;
    valid_d  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    mem_we   = 1'b0;
`ifdef MEM_ERR_EN
    err_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d   = addr;
          wr_d     = wr;
          data_d   = data;
          cnt_load = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_zero) begin
`ifdef MEM_ERR_EN
          err_d = oor;
`endif
          if (wr_q) begin
            mem_we  = !oor;
            state_d = IDLE;
          end else begin
            q_d     = oor ? '0 : mem[idx];
            valid_d = 1'b1;
            state_d = RESP;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
`ifdef MEM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      q_q     <= q_d;
      valid_q <= valid_d;
`ifdef MEM_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Storage is deliberately not reset; an aborted write never reaches here because mem_we is WAIT-only.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[idx] <= data_q;
    end
  end

  assign ready = (state_q == IDLE);
  assign valid = valid_q;
  assign q     = q_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder: LATENCY=4 and LATENCY=1 instances,
// directed handshake/reset cases plus randomized traffic against a word-array model.
module tb_main_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, wr;
  logic [31:0] addr, data;
  logic        ready0, ready1, valid0, valid1;
  logic [31:0] q0, q1;
`ifdef MEM_ERR_EN
  logic        err0, err1;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m0 [int];
  logic [31:0] m1 [int];

  always #5 clk = ~clk;

  main_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(10), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .req(req0), .wr(wr), .addr(addr), .data(data),
    .ready(ready0), .valid(valid0),
`ifdef MEM_ERR_EN
    .err(err0),
`endif
    .q(q0));

  main_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .wr(wr), .addr(addr), .data(data),
    .ready(ready1), .valid(valid1),
`ifdef MEM_ERR_EN
    .err(err1),
`endif
    .q(q1));

  function automatic logic rdy(input bit s);
    return s ? ready1 : ready0;
  endfunction
  function automatic logic vld(input bit s);
    return s ? valid1 : valid0;
  endfunction
  function automatic logic [31:0] qq(input bit s);
    return s ? q1 : q0;
  endfunction
  function automatic logic er(input bit s);
`ifdef MEM_ERR_EN
    return s ? err1 : err0;
`else
    return s & 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction
  function automatic bit out_of_range(input logic [31:0] a);
`ifdef MEM_ERR_EN
    return a >= 32'h0000_1000;
`else
    return a == 32'hFFFF_FFFF && 1'b0;
`endif
  endfunction
  function automatic logic [31:0] mget(input bit s, input logic [31:0] a);
    int i = widx(a);
    if (s) return m1.exists(i) ? m1[i] : 32'h0;
    return m0.exists(i) ? m0[i] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit s, input logic v);
    if (s) req1 = v; else req0 = v;
  endtask

  // One full transaction; n counts falling edges after the accepting rising edge.
  task automatic op(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d,
                    input string tag);
    int lat = s ? 1 : 4;
    int n = 1, vat = 0, vcnt = 0, rat = 0, eat = 0, ecnt = 0;
    logic [31:0] rq = '0;
    logic [31:0] exp;
    bit oor = out_of_range(a);
    exp = oor ? 32'h0 : mget(s, a);
    @(negedge clk);
    chk({tag, "_rdy_pre"}, 32'(rdy(s)), 32'd1);
    wr = w; addr = a; data = d;
    set_req(s, 1'b1);
    @(negedge clk);
    set_req(s, 1'b0);
    while (n <= 20) begin
      if (vld(s)) begin vcnt++; vat = n; rq = qq(s); end
      if (er(s)) begin ecnt++; eat = n; end
      if (rdy(s)) begin rat = n; break; end
      @(negedge clk);
      n++;
    end
    if (w) begin
      chk({tag, "_wr_ready_at"}, 32'(rat), 32'(lat + 1));
      chk({tag, "_wr_no_valid"}, 32'(vcnt), 32'd0);
      if (!oor) begin
        if (s) m1[widx(a)] = d; else m0[widx(a)] = d;
      end
    end else begin
      chk({tag, "_rd_valid_at"}, 32'(vat), 32'(lat + 1));
      chk({tag, "_rd_valid_cnt"}, 32'(vcnt), 32'd1);
      chk({tag, "_rd_q"}, rq, exp);
      chk({tag, "_rd_ready_at"}, 32'(rat), 32'(lat + 2));
      chk({tag, "_rd_q_hold"}, qq(s), exp);
    end
`ifdef MEM_ERR_EN
    chk({tag, "_err_cnt"}, 32'(ecnt), oor ? 32'd1 : 32'd0);
    if (oor) chk({tag, "_err_at"}, 32'(eat), 32'(lat + 1));
`endif
  endtask

  initial begin
    int lowcnt, vc, n, vat;
    logic [31:0] rq;
    int unsigned pool [8];
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; wr = 1'b0; addr = '0; data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready0", 32'(ready0), 32'd1);
    chk("rst_valid0", 32'(valid0), 32'd0);
    chk("rst_q0", q0, 32'd0);
    chk("rst_ready1", 32'(ready1), 32'd1);
    chk("rst_q1", q1, 32'd0);

    // 1 and 3: basic write/read, byte offset ignored
    op(0, 1, 32'h10, 32'hDEAD_BEEF, "t1_wr");
    op(0, 0, 32'h10, 32'h0, "t1_rd");
    op(0, 1, 32'h13, 32'h55, "t3_wr");
    op(0, 0, 32'h10, 32'h0, "t3_rd");
    op(0, 1, 32'h40, 32'h1234_5678, "t2_prep");

    // 2: request held every cycle; only one accepted until IDLE returns
    @(negedge clk);
    wr = 1'b0; addr = 32'h10; req0 = 1'b1;
    lowcnt = 0; vc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      addr = 32'h40;
      if (valid0) begin vc++; chk("t2_first_q", q0, mget(0, 32'h10)); end
      if (ready0) break;
      lowcnt++;
    end
    chk("t2_ready_low_cycles", 32'(lowcnt), 32'd5);
    chk("t2_first_valid_cnt", 32'(vc), 32'd1);
    @(negedge clk);
    chk("t2_second_accepted", 32'(ready0), 32'd0);
    req0 = 1'b0;
    n = 1; vat = 0; rq = '0;
    while (n <= 20 && !ready0) begin
      if (valid0) begin vat = n; rq = q0; end
      @(negedge clk);
      n++;
    end
    chk("t2_second_valid_at", 32'(vat), 32'd5);
    chk("t2_second_q", rq, mget(0, 32'h40));

    // 4: reset during WAIT aborts the write
    op(0, 1, 32'h20, 32'h0, "t4_prep");
    @(negedge clk);
    wr = 1'b1; addr = 32'h20; data = 32'h1; req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_rst_ready", 32'(ready0), 32'd1);
    chk("t4_rst_valid", 32'(valid0), 32'd0);
    chk("t4_rst_q", q0, 32'd0);
    op(0, 0, 32'h20, 32'h0, "t4_rd");

    // reset while RESP: valid and q cleared
    op(0, 0, 32'h10, 32'h0, "resp_prep");
    @(negedge clk);
    wr = 1'b0; addr = 32'h40; req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("resp_valid_before_rst", 32'(valid0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("resp_rst_valid", 32'(valid0), 32'd0);
    chk("resp_rst_q", q0, 32'd0);
    chk("resp_rst_ready", 32'(ready0), 32'd1);

`ifdef MEM_ERR_EN
    // 5: out-of-range accesses
    op(0, 1, 32'h0, 32'hCAFE_0000, "t5_prep");
    op(0, 0, 32'h0010_0000, 32'h0, "t5_oor_rd");
    op(0, 1, 32'h0010_0000, 32'hBAD0_BAD0, "t5_oor_wr");
    op(0, 0, 32'h0, 32'h0, "t5_unchanged");
`endif

    // randomized traffic over a small word pool, with aliasing upper bits when legal
    for (int i = 0; i < 8; i++) begin
      pool[i] = $urandom_range(1023);
      op(0, 1, pool[i] << 2, $urandom, "rnd_init");
    end
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = (pool[$urandom_range(7)] << 2) | $urandom_range(3);
`ifndef MEM_ERR_EN
      a = a | ($urandom << 12);
`endif
      op(0, bit'($urandom_range(1)), a, $urandom, "rnd");
    end

    // 6: LATENCY=1 instance, single read then sustained held-request reads
    op(1, 1, 32'h10, 32'hA5A5_0001, "t6_wr");
    op(1, 0, 32'h10, 32'h0, "t6_rd");
    @(negedge clk);
    wr = 1'b0; addr = 32'h10; req1 = 1'b1;
    vc = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid1) begin
        vc++;
        chk("t6_b2b_q", q1, mget(1, 32'h10));
      end
    end
    req1 = 1'b0;
    chk("t6_b2b_count", 32'(vc), 32'd4);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
